hazard_ctrl: RTL

Central hazard and pipeline-control unit for the five-stage RISC-V pipeline. It reads the register addresses and control bits carried by the ID/EX, EX/MEM and MEM/WB pipeline registers. It drives their stall (write-enable) and flush (bubble) controls, plus the EX-stage forwarding selects. A small FSM freezes the whole pipeline while the data memory has not acknowledged an access, and raises a fault on timeout. Performance counters record stall and flush activity.

---
 rtl/riscv_pipe_pkg.sv | 37 +++
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/memwait_fsm.sv | 70 +++++++
 rtl/hazard_ctrl.sv | 96 +++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared encodings for the five-stage pipeline control path: result selects,
// forwarding selects, memory-wait FSM states and the forwarding priority rule.
package riscv_pipe_pkg;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_WAIT  = 2'b01,
      ST_FAULT = 2'b10
   } memwait_state_e;

   // Memory stage holds the younger result, so it beats Writeback; x0 never forwards.
   function automatic logic [1:0] fwdSel(input logic       regWriteM,
                                         input logic [4:0] rdM,
                                         input logic       regWriteW,
                                         input logic [4:0] rdW,
                                         input logic [4:0] rs);
      logic [1:0] sel;
      sel = FWD_RF;
      if (rs != 5'd0) begin
         if (regWriteM && (rdM == rs)) begin
            sel = FWD_MEM;
         end else if (regWriteW && (rdW == rs)) begin
            sel = FWD_WB;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-register fields seen by the hazard unit and the
// stall/flush/forward controls and counters it returns to the datapath.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       Rs1D, Rs2D;
   logic [4:0]       Rs1E, Rs2E, RdE;
   logic [1:0]       ResultSrcE;
   logic             PCSrcE;
   logic [4:0]       RdM, RdW;
   logic             RegWriteM, RegWriteW;
   logic             MemReqM, MemReadyM;

   logic [1:0]       ForwardAE, ForwardBE;
   logic             StallF, StallD, StallE, StallM;
   logic             FlushD, FlushE, FlushW;
   logic             memFault;
   logic [CNT_W-1:0] lwStallCnt, flushCnt, memStallCnt;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
             RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
             FlushD, FlushE, FlushW, memFault,
             lwStallCnt, flushCnt, memStallCnt
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
             RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
      output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
             FlushD, FlushE, FlushW, memFault,
             lwStallCnt, flushCnt, memStallCnt
   );

endinterface

// File: rtl/memwait_fsm.sv
// Freezes the pipeline while a data-memory access is outstanding and latches a
// fault once the access has stalled for TIMEOUT consecutive cycles.
module memwait_fsm
   import riscv_pipe_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic memReq_i,
   input  logic memReady_i,
   output logic memStall_o,
   output logic memFault_o
);

   localparam int WCW = $clog2(TIMEOUT + 1);

   memwait_state_e state_q, state_d;
   logic [WCW-1:0] waitCnt_q, waitCnt_d;
   logic           memMiss;

   assign memMiss = memReq_i && !memReady_i;

   // The RUN miss cycle is stall number one, so entering WAIT already counts one.
   always_comb begin
      state_d    = state_q;
      waitCnt_d  = waitCnt_q;
      memStall_o = 1'b0;
      case (state_q)
         ST_RUN: begin
            memStall_o = memMiss;
            if (memMiss) begin
               state_d   = ST_WAIT;
               waitCnt_d = WCW'(1);
            end
         end
         ST_WAIT: begin
            memStall_o = 1'b1;
            if (memReady_i) begin
               state_d   = ST_RUN;
               waitCnt_d = '0;
            end else if (waitCnt_q == WCW'(TIMEOUT - 1)) begin
               state_d = ST_FAULT;
            end else begin
               waitCnt_d = waitCnt_q + WCW'(1);
            end
         end
         ST_FAULT: begin
            memStall_o = 1'b1;
         end
         default: begin
            state_d   = ST_RUN;
            waitCnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_RUN;
         waitCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
      end
   end

   assign memFault_o = (state_q == ST_FAULT);

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard unit: EX forwarding, load-use stall, branch flush, whole-pipe
// freeze on data-memory wait, and stall/flush performance counters.
module hazard_ctrl
   import riscv_pipe_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input logic          clk,
   input logic          reset,
   hazard_ctrl_if.slave hz
);

   logic             memStall, memFault, lwStall;
   logic [CNT_W-1:0] lwStallCnt_q, lwStallCnt_d;
   logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
   logic [CNT_W-1:0] memStallCnt_q, memStallCnt_d;

   memwait_fsm #(
      .TIMEOUT(TIMEOUT)
   ) u_memwait (
      .clk        (clk),
      .reset      (reset),
      .memReq_i   (hz.MemReqM),
      .memReady_i (hz.MemReadyM),
      .memStall_o (memStall),
      .memFault_o (memFault)
   );

   assign lwStall = (hz.ResultSrcE == RES_MEM) && (hz.RdE != 5'd0) &&
                    ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));

   // A memory freeze overrides load-use and branch effects; the frozen EX
   // instruction presents its branch again once the pipeline is released.
   always_comb begin
      hz.ForwardAE = FWD_RF;
      hz.ForwardBE = FWD_RF;
      hz.StallF    = 1'b0;
      hz.StallD    = 1'b0;
      hz.StallE    = 1'b0;
      hz.StallM    = 1'b0;
      hz.FlushD    = 1'b0;
      hz.FlushE    = 1'b0;
      hz.FlushW    = 1'b0;
      if (!reset) begin
         hz.ForwardAE = fwdSel(hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW, hz.Rs1E);
         hz.ForwardBE = fwdSel(hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW, hz.Rs2E);
         if (memStall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.StallM = 1'b1;
            hz.FlushW = 1'b1;
         end else begin
            hz.StallF = lwStall;
            hz.StallD = lwStall;
            hz.FlushD = hz.PCSrcE;
            hz.FlushE = lwStall || hz.PCSrcE;
         end
      end
   end

   // Counters record only effects that actually reach the pipeline.
   always_comb begin
      lwStallCnt_d  = lwStallCnt_q;
      flushCnt_d    = flushCnt_q;
      memStallCnt_d = memStallCnt_q;
      if (!memStall && lwStall) begin
         lwStallCnt_d = lwStallCnt_q + CNT_W'(1);
      end
      if (!memStall && hz.PCSrcE) begin
         flushCnt_d = flushCnt_q + CNT_W'(1);
      end
      if (memStall && !memFault) begin
         memStallCnt_d = memStallCnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lwStallCnt_q  <= '0;
         flushCnt_q    <= '0;
         memStallCnt_q <= '0;
      end else begin
         lwStallCnt_q  <= lwStallCnt_d;
         flushCnt_q    <= flushCnt_d;
         memStallCnt_q <= memStallCnt_d;
      end
   end

   assign hz.memFault    = memFault;
   assign hz.lwStallCnt  = lwStallCnt_q;
   assign hz.flushCnt    = flushCnt_q;
   assign hz.memStallCnt = memStallCnt_q;

endmodule
